// File: rtl/bcd_freq_synth.sv
// Programmable square-wave generator: packed-BCD target frequency -> binary -> half-period
// count (CLK_HZ / (2*f)) -> toggling output, with glitch-free switching between settings.
module bcd_freq_synth #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic        iCLK,
  input  logic        reset,
  input  logic [31:0] ifreqnum,
  input  logic        iload,
  output logic        obusy,
  output logic        odone,
  output logic        oerr,
  output logic        ofreq_clk,
  output logic [31:0] oactive_bcd
);

  localparam logic [31:0] CLK_VEC = 32'(CLK_HZ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_DIV   = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  step_r;
  logic [31:0] shift_r;
  logic [31:0] bcd_req_r;
  logic [26:0] acc_r;
  logic        err_r;
  logic [27:0] rem_r;
  logic [31:0] quo_r;
  logic        obusy_r;

  logic [31:0] h_act_r;
  logic [31:0] gen_cnt_r;
  logic        pend_valid_r;
  logic [31:0] pend_h_r;
  logic [31:0] pend_bcd_r;
  logic        odone_r;
  logic        oerr_r;
  logic        ofreq_r;
  logic [31:0] oactive_r;

  logic [3:0]  digit_s;
  logic [26:0] acc_next_s;
  logic [27:0] div_d_s;
  logic [28:0] rem_shift_s;
  logic        sub_ok_s;
  logic [27:0] rem_next_s;
  logic        chk_s;
  logic        disable_s;
  logic        accept_s;
  logic        reject_s;
  logic        tog_s;

  assign digit_s     = shift_r[31:28];
  assign acc_next_s  = 27'(acc_r * 27'd10 + {23'd0, digit_s});
  assign div_d_s     = {acc_r, 1'b0};
  assign rem_shift_s = {rem_r, CLK_VEC[5'd31 - step_r]};
  // A zero divisor never subtracts; the CHECK decision discards that result anyway.
  assign sub_ok_s    = (div_d_s != 28'd0) && (rem_shift_s >= {1'b0, div_d_s});
  assign rem_next_s  = sub_ok_s ? 28'(rem_shift_s - {1'b0, div_d_s}) : rem_shift_s[27:0];

  assign chk_s     = (state_r == S_CHECK);
  assign disable_s = chk_s && !err_r && (acc_r == 27'd0);
  assign accept_s  = chk_s && !err_r && (acc_r != 27'd0) && (quo_r != 32'd0);
  assign reject_s  = chk_s && (err_r || ((acc_r != 27'd0) && (quo_r == 32'd0)));
  assign tog_s     = (h_act_r != 32'd0) && (gen_cnt_r == h_act_r - 32'd1);

  assign obusy       = obusy_r;
  assign odone       = odone_r;
  assign oerr        = oerr_r;
  assign ofreq_clk   = ofreq_r;
  assign oactive_bcd = oactive_r;

  // FSM state register
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (iload) state_s = S_CONV; else state_s = S_IDLE;
      S_CONV:  if (step_r == 5'd7) state_s = S_DIV; else state_s = S_CONV;
      S_DIV:   if (step_r == 5'd31) state_s = S_CHECK; else state_s = S_DIV;
      S_CHECK: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Request capture, BCD-to-binary conversion and restoring divide
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset) begin
      step_r    <= 5'd0;
      shift_r   <= 32'd0;
      bcd_req_r <= 32'd0;
      acc_r     <= 27'd0;
      err_r     <= 1'b0;
      rem_r     <= 28'd0;
      quo_r     <= 32'd0;
      obusy_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (iload) begin
            shift_r   <= ifreqnum;
            bcd_req_r <= ifreqnum;
            acc_r     <= 27'd0;
            err_r     <= 1'b0;
            rem_r     <= 28'd0;
            quo_r     <= 32'd0;
            step_r    <= 5'd0;
            obusy_r   <= 1'b1;
          end
        end
        S_CONV: begin
          shift_r <= {shift_r[27:0], 4'd0};
          acc_r   <= acc_next_s;
          err_r   <= err_r | (digit_s > 4'd9);
          step_r  <= (step_r == 5'd7) ? 5'd0 : step_r + 5'd1;
        end
        S_DIV: begin
          rem_r  <= rem_next_s;
          quo_r  <= {quo_r[30:0], sub_ok_s};
          step_r <= step_r + 5'd1;
        end
        S_CHECK: begin
          obusy_r <= 1'b0;
          step_r  <= 5'd0;
        end
        default: begin
          step_r <= 5'd0;
        end
      endcase
    end
  end

  // Result reporting, pending slot and square-wave generator
  always_ff @(posedge iCLK or negedge reset) begin
    if (!reset) begin
      h_act_r      <= 32'd0;
      gen_cnt_r    <= 32'd0;
      pend_valid_r <= 1'b0;
      pend_h_r     <= 32'd0;
      pend_bcd_r   <= 32'd0;
      odone_r      <= 1'b0;
      oerr_r       <= 1'b0;
      ofreq_r      <= 1'b0;
      oactive_r    <= 32'd0;
    end else begin
      odone_r <= chk_s;
      if (chk_s) oerr_r <= reject_s;
      if (disable_s) begin
        h_act_r      <= 32'd0;
        gen_cnt_r    <= 32'd0;
        ofreq_r      <= 1'b0;
        oactive_r    <= 32'd0;
        pend_valid_r <= 1'b0;
      end else begin
        if (h_act_r == 32'd0) begin
          // Idle generator: start immediately; first rising edge one full half-period later.
          if (pend_valid_r) begin
            h_act_r      <= pend_h_r;
            oactive_r    <= pend_bcd_r;
            gen_cnt_r    <= 32'd0;
            pend_valid_r <= 1'b0;
          end
        end else if (tog_s) begin
          ofreq_r   <= ~ofreq_r;
          gen_cnt_r <= 32'd0;
          if (pend_valid_r) begin
            h_act_r      <= pend_h_r;
            oactive_r    <= pend_bcd_r;
            pend_valid_r <= 1'b0;
          end
        end else begin
          gen_cnt_r <= gen_cnt_r + 32'd1;
        end
        // A newly accepted value overrides any pending one, including one consumed this edge.
        if (accept_s) begin
          pend_valid_r <= 1'b1;
          pend_h_r     <= quo_r;
          pend_bcd_r   <= bcd_req_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_freq_synth.sv
// Directed bench: dut_a runs at 50 MHz (latency, decisions, H=1 toggling); dut_b uses a
// 50 kHz numerator so that half-periods (25, 12, 8333 cycles) can be timed exactly.
module tb_bcd_freq_synth;

  logic        iCLK = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ifreqnum = 32'd0;
  logic        iload = 1'b0;
  logic        obusy_a, odone_a, oerr_a, ofreq_a;
  logic [31:0] oactive_a;
  logic        obusy_b, odone_b, oerr_b, ofreq_b;
  logic [31:0] oactive_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = -1;
  int tog_q[$];
  logic prev_b = 1'b0;

  bcd_freq_synth #(.CLK_HZ(50000000)) dut_a (
    .iCLK(iCLK), .reset(reset), .ifreqnum(ifreqnum), .iload(iload),
    .obusy(obusy_a), .odone(odone_a), .oerr(oerr_a), .ofreq_clk(ofreq_a), .oactive_bcd(oactive_a)
  );

  bcd_freq_synth #(.CLK_HZ(50000)) dut_b (
    .iCLK(iCLK), .reset(reset), .ifreqnum(ifreqnum), .iload(iload),
    .obusy(obusy_b), .odone(odone_b), .oerr(oerr_b), .ofreq_clk(ofreq_b), .oactive_bcd(oactive_b)
  );

  always #5 iCLK = ~iCLK;

  // Advance to the next falling edge; cyc is the index of the rising edge just passed.
  task automatic step();
    @(negedge iCLK);
    cyc++;
    if (ofreq_b !== prev_b) begin
      tog_q.push_back(cyc);
      prev_b = ofreq_b;
    end
    if (odone_a === 1'b1) begin
      done_cnt++;
      last_done = cyc;
    end
  endtask

  task automatic start_load(input logic [31:0] bcd, output int s);
    ifreqnum = bcd;
    iload = 1'b1;
    step();
    iload = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(output int e, output bit ok);
    ok = 1'b0;
    e = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      if (odone_a === 1'b1) begin
        ok = 1'b1;
        e = cyc;
      end
    end
  endtask

  task automatic test_reset();
    step(); step(); step();
    checks++;
    if ({obusy_a, odone_a, oerr_a, ofreq_a, oactive_a} !== 36'd0)
      $display("FAIL reset_a: got %h want 0", {obusy_a, odone_a, oerr_a, ofreq_a, oactive_a});
    checks++;
    if ({obusy_b, odone_b, oerr_b, ofreq_b, oactive_b} !== 36'd0)
      $display("FAIL reset_b: got %h want 0", {obusy_b, odone_b, oerr_b, ofreq_b, oactive_b});
    reset = 1'b1;
    step(); step();
    checks++;
    if ({obusy_a, odone_a, oerr_a, ofreq_a, oactive_a, ofreq_b, oactive_b} !== 69'd0)
      $display("FAIL after_reset: outputs not 0 (ofreq_b=%b oactive_b=%h)", ofreq_b, oactive_b);
  endtask

  task automatic test_fast();
    int s, e;
    bit ok;
    logic v;
    start_load(32'h25000000, s);
    checks++;
    if (obusy_a !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", obusy_a); end
    wait_done(e, ok);
    checks++;
    if (!ok || e - s != 41) begin errors++; $display("FAIL latency_fast: got %0d want 41", ok ? e - s : -1); end
    checks++;
    if (odone_b !== 1'b1 || obusy_a !== 1'b0) begin
      errors++; $display("FAIL done_busy_fast: odone_b=%b obusy_a=%b want 1 0", odone_b, obusy_a);
    end
    checks++;
    if (oerr_a !== 1'b0 || oerr_b !== 1'b1) begin
      errors++; $display("FAIL err_fast: a=%b b=%b want 0 1", oerr_a, oerr_b);
    end
    step();
    checks++;
    if (oactive_a !== 32'h25000000 || ofreq_a !== 1'b0 || oactive_b !== 32'd0) begin
      errors++; $display("FAIL apply_fast: act_a=%h clk_a=%b act_b=%h want 25000000 0 0", oactive_a, ofreq_a, oactive_b);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ofreq_a !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL toggle_h1[%0d]: got %b want %b", i, ofreq_a, (i % 2 == 0));
      end
    end
    start_load(32'h25000001, s);
    wait_done(e, ok);
    checks++;
    if (!ok || oerr_a !== 1'b1 || oerr_b !== 1'b1 || oactive_a !== 32'h25000000) begin
      errors++; $display("FAIL over_limit: ok=%b err_a=%b err_b=%b act_a=%h want 1 1 1 25000000", ok, oerr_a, oerr_b, oactive_a);
    end
    for (int i = 0; i < 4; i++) begin
      v = ofreq_a;
      step();
      checks++;
      if (ofreq_a !== ~v) begin errors++; $display("FAIL keep_toggle[%0d]: got %b want %b", i, ofreq_a, ~v); end
    end
  endtask

  task automatic test_disable();
    int s, e;
    bit ok;
    logic any_high;
    start_load(32'h00000000, s);
    wait_done(e, ok);
    checks++;
    if (!ok || e - s != 41) begin errors++; $display("FAIL latency_off: got %0d want 41", ok ? e - s : -1); end
    checks++;
    if ({oerr_a, oerr_b, ofreq_a, ofreq_b} !== 4'b0000 || oactive_a !== 32'd0 || oactive_b !== 32'd0) begin
      errors++; $display("FAIL disable: err=%b%b clk=%b%b act=%h/%h want all 0", oerr_a, oerr_b, ofreq_a, ofreq_b, oactive_a, oactive_b);
    end
    any_high = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      any_high = any_high | ofreq_a | ofreq_b;
    end
    checks++;
    if (any_high !== 1'b0) begin errors++; $display("FAIL stay_low: got %b want 0", any_high); end
  endtask

  task automatic test_load_1k();
    int s, e;
    bit ok;
    start_load(32'h00001000, s);
    wait_done(e, ok);
    checks++;
    if (!ok || e - s != 41) begin errors++; $display("FAIL latency_1k: got %0d want 41", ok ? e - s : -1); end
    checks++;
    if (oerr_a !== 1'b0 || oerr_b !== 1'b0 || oactive_b !== 32'd0) begin
      errors++; $display("FAIL done_1k: err=%b%b act_b=%h want 0 0 0", oerr_a, oerr_b, oactive_b);
    end
    tog_q.delete();
    while (cyc < e + 60) step();
    checks++;
    if (oactive_a !== 32'h00001000 || oactive_b !== 32'h00001000 || ofreq_a !== 1'b0) begin
      errors++; $display("FAIL active_1k: a=%h b=%h clk_a=%b want 1000 1000 0", oactive_a, oactive_b, ofreq_a);
    end
    checks++;
    if (tog_q.size() < 2) begin
      errors++; $display("FAIL period_1k: got %0d toggles want >=2", tog_q.size());
    end else if (tog_q[0] != e + 26 || tog_q[1] - tog_q[0] != 25) begin
      errors++; $display("FAIL period_1k: first=%0d half=%0d want 26 25", tog_q[0] - e, tog_q[1] - tog_q[0]);
    end
  endtask

  task automatic test_invalid();
    int s, e;
    bit ok;
    start_load(32'h000000A0, s);
    wait_done(e, ok);
    checks++;
    if (!ok || e - s != 41 || oerr_a !== 1'b1 || oerr_b !== 1'b1) begin
      errors++; $display("FAIL invalid_err: lat=%0d err=%b%b want 41 1 1", ok ? e - s : -1, oerr_a, oerr_b);
    end
    checks++;
    if (oactive_a !== 32'h00001000 || oactive_b !== 32'h00001000) begin
      errors++; $display("FAIL invalid_keep: a=%h b=%h want 1000", oactive_a, oactive_b);
    end
    tog_q.delete();
    for (int i = 0; i < 60; i++) step();
    checks++;
    if (tog_q.size() < 2 || tog_q[1] - tog_q[0] != 25) begin
      errors++; $display("FAIL invalid_period: got %0d want 25", (tog_q.size() < 2) ? -1 : tog_q[1] - tog_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int s, base;
    tog_q.delete();
    for (int i = 0; i < 40 && tog_q.size() == 0; i++) step();
    for (int i = 0; i < 5; i++) step();
    start_load(32'h00002000, s);
    base = done_cnt;
    for (int i = 0; i < 10; i++) step();
    ifreqnum = 32'h00009000;
    iload = 1'b1;
    step();
    iload = 1'b0;
    while (cyc < s + 101) step();
    checks++;
    if (done_cnt - base != 1 || last_done != s + 41) begin
      errors++; $display("FAIL busy_ignore: dones=%0d at=%0d want 1 at %0d", done_cnt - base, last_done - s, 41);
    end
    checks++;
    if (oactive_b !== 32'h00002000 || oerr_b !== 1'b0) begin
      errors++; $display("FAIL switch_active: got %h err=%b want 2000 0", oactive_b, oerr_b);
    end
    checks++;
    if (tog_q.size() < 5) begin
      errors++; $display("FAIL switch_halves: got %0d toggles want >=5", tog_q.size());
    end else if (tog_q[1] - tog_q[0] != 25 || tog_q[2] - tog_q[1] != 25 ||
                 tog_q[3] - tog_q[2] != 12 || tog_q[4] - tog_q[3] != 12) begin
      errors++; $display("FAIL switch_halves: got %0d %0d %0d %0d want 25 25 12 12",
        tog_q[1] - tog_q[0], tog_q[2] - tog_q[1], tog_q[3] - tog_q[2], tog_q[4] - tog_q[3]);
    end
  endtask

  task automatic test_3hz();
    int s, e;
    bit ok;
    start_load(32'h00000003, s);
    wait_done(e, ok);
    checks++;
    if (!ok || oerr_a !== 1'b0 || oerr_b !== 1'b0) begin
      errors++; $display("FAIL err_3hz: ok=%b err=%b%b want 1 0 0", ok, oerr_a, oerr_b);
    end
    tog_q.delete();
    for (int i = 0; i < 9000 && tog_q.size() < 2; i++) step();
    checks++;
    if (tog_q.size() < 2) begin
      errors++; $display("FAIL half_3hz: got %0d toggles want 2", tog_q.size());
    end else if (tog_q[0] - e > 12 || tog_q[0] <= e || tog_q[1] - tog_q[0] != 8333) begin
      errors++; $display("FAIL half_3hz: apply=%0d half=%0d want <=12 8333", tog_q[0] - e, tog_q[1] - tog_q[0]);
    end
    checks++;
    if (oactive_b !== 32'h00000003) begin errors++; $display("FAIL active_3hz: got %h want 3", oactive_b); end
  endtask

  task automatic test_reset_mid();
    int s, e, base;
    bit ok;
    logic any_bad;
    start_load(32'h00001000, s);
    wait_done(e, ok);
    step(); step();
    start_load(32'h00002000, s);
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (obusy_a !== 1'b1 || oactive_a !== 32'h00001000) begin
      errors++; $display("FAIL pre_reset: busy=%b act=%h want 1 1000", obusy_a, oactive_a);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({obusy_a, odone_a, oerr_a, ofreq_a, oactive_a, obusy_b, odone_b, oerr_b, ofreq_b, oactive_b} !== 72'd0) begin
      errors++; $display("FAIL async_reset: act_a=%h act_b=%h busy=%b%b want 0", oactive_a, oactive_b, obusy_a, obusy_b);
    end
    step(); step();
    reset = 1'b1;
    base = done_cnt;
    any_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      any_bad = any_bad | ofreq_a | ofreq_b | obusy_a | (oactive_b != 32'd0);
    end
    checks++;
    if (done_cnt != base || any_bad !== 1'b0) begin
      errors++; $display("FAIL post_reset: dones=%0d activity=%b want 0 0", done_cnt - base, any_bad);
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_disable();
    test_load_1k();
    test_invalid();
    test_back_to_back();
    test_3hz();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // The reset checks above report through their own display; count them here too.
  always @(negedge iCLK) begin
    if (cyc == 3 && {obusy_a, odone_a, oerr_a, ofreq_a, oactive_a, obusy_b, odone_b, oerr_b, ofreq_b, oactive_b} !== 72'd0)
      errors++;
  end

endmodule
